fp16_argmax_stream: RTL
=======================

Name: fp16_argmax_stream

Overview:
- Streaming successor to the combinational FP16 one-hot classifier stage at the end of the DNN pipeline.
- Takes an N-element FP16 logit vector over ceil(N/LANES) beats through a valid/ready handshake. Keeps a running maximum and its index.
- After the last beat, presents the one-hot vector, binary index and winning value, and holds them until downstream accepts.
- Decouples classifier width from the output-layer datapath width.

Parameters:
- N, 10, logits per vector (N >= 2)
- LANES, 1, FP16 elements per input beat (1 <= LANES <= N)
- IDX_W, $clog2(N), index width (derived, not overridable)
- BEATS, (N+LANES-1)/LANES, beats per vector (derived)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  LANES*16  lane k = bits [16k+15:16k], carries element beat*LANES+k
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_onehot  out  N  bit i set means element i is max; exactly one bit set when out_valid
- out_idx  out  IDX_W  binary index of the max
- out_max  out  16  FP16 value of the max, bit-exact as received
- out_all_nan  out  1  every element was NaN

Behaviour:
- Reset (async assert, sync deassert) sets all outputs and state to these values:
  - state=IDLE, beat counter=0
  - in_ready=0 during reset; in_ready=1 in the first cycle after deassert
  - out_valid=0, out_onehot=0, out_idx=0, out_max=16'h0000, out_all_nan=0
- State machine ACCUM/HOLD (IDLE is the reset-only alias of ACCUM with counter=0):
  - ACCUM: in_ready=1. A beat transfers on in_valid & in_ready. Counter increments per beat.
  - On the transfer with counter==BEATS-1: latch the result, set counter to 0, go to HOLD.
  - HOLD: out_valid=1. Outputs stay stable until out_valid & out_ready. Then return to ACCUM.
  - in_ready = (state==ACCUM) | out_ready. A first beat of the next vector may transfer in the same cycle the current result is accepted.
- Latency: out_valid rises on the cycle after the final beat transfers. With in_valid held high and out_ready high, throughput is one vector per BEATS cycles.
- Per-beat reduction:
  - A combinational tree over the LANES lanes finds the beat winner.
  - The beat winner is then compared against the running max.
  - On beat 0, the running max is loaded from the beat winner rather than compared.
- Padding lanes:
  - Lanes with element index >= N (only in the last beat when N % LANES != 0) are masked out and never win, whatever their value.
- FP16 ordering:
  - sign-magnitude compare: positives compare by {exp,frac} ascending, negatives by descending.
  - +0 and -0 compare equal.
  - +inf and -inf are ordinary extremes.
  - NaN (exp=31, frac!=0) ranks below every non-NaN value, including -inf.
- Ties: the strictly-greater rule applies, so the lowest index wins. This covers equal values, ±0, and all-NaN.
- All-NaN vector: out_idx=0, out_onehot bit 0 set, out_max = element 0, out_all_nan=1.
- Idle beats: in_valid low mid-vector inserts stall cycles; the counter and running max hold.
- Reset mid-vector discards the partial vector. A partial vector is never emitted.
- Width: out_onehot is decoded from out_idx at latch time and registered, not decoded combinationally.

Decomposition:
- Package fp16_pkg:
  - typedef fp16_t (16-bit packed)
  - localparams FP16_EXP_MAX=5'd31, FP16_NEG_INF=16'hFC00
  - function fp16_is_nan
  - function fp16_gt (ordering above)
- Sub-module fp16_max2:
  - Combinational two-input max with index pass-through and valid masks.
  - Instantiated LANES-1 times in the lane tree, plus once for the running-max compare.

Test Plan:
- N=10, LANES=1, input {1.0(3C00), 2.0(4000) at idx 7, rest 0} over 10 beats -> out_valid on the 11th cycle, out_idx=7, out_onehot=10'b0010000000, out_max=16'h4000.
- N=10, LANES=4:
  - 3 beats, element 9 = 16'h3800 is the max among real elements; padding lanes 10,11 = 16'h7C00 (+inf)
  - -> out_idx=9, out_max=16'h3800 (padding ignored).
- Ties and negatives:
  - elements 2 and 5 both 16'h4200 -> out_idx=2.
  - all elements negative, -0.5 (B800) at idx 4 is largest -> out_idx=4.
  - idx0=16'h8000 (-0), idx1=16'h0000 (+0), rest negative -> out_idx=0.
- NaN:
  - 16'h7E00 at idx 3 among finite values -> never selected.
  - all elements 16'h7E00 -> out_idx=0, out_all_nan=1.
- Backpressure:
  - out_ready=0 for 5 cycles -> in_ready=0, outputs stable.
  - out_ready=1 with in_valid=1 -> result accepted and next vector's beat 0 transfers in the same cycle. Two back-to-back vectors yield correct independent results.
- rst_n pulsed low mid-vector (after beat 1 of 3) -> immediate out_valid=0 and outputs zero. The next full vector is produced correctly with no residue.

Source files
------------

// File: rtl/fp16_pkg.sv
// FP16 helpers shared by the argmax datapath: NaN detection and a total "greater than"
// order where NaN sits below every real value, including -inf.
package fp16_pkg;

    typedef logic [15:0] fp16_t;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } argmax_state_t;

    localparam logic [4:0] FP16_EXP_MAX = 5'd31;
    localparam fp16_t      FP16_NEG_INF = 16'hFC00;

    function automatic logic fp16_is_nan(input fp16_t v);
        return (v[14:10] == FP16_EXP_MAX) && (v[9:0] != 10'd0);
    endfunction

    function automatic logic fp16_is_zero(input fp16_t v);
        return v[14:0] == 15'd0;
    endfunction

    // Strictly greater; equal values (including +0 vs -0) return 0 so the lower index keeps the win.
    function automatic logic fp16_gt(input fp16_t a, input fp16_t b);
        logic r;
        if (fp16_is_nan(a))                         r = 1'b0;
        else if (fp16_is_nan(b))                    r = 1'b1;
        else if (fp16_is_zero(a) && fp16_is_zero(b)) r = 1'b0;
        else if (a[15] != b[15])                    r = ~a[15];
        else if (!a[15])                            r = a[14:0] > b[14:0];
        else                                        r = a[14:0] < b[14:0];
        return r;
    endfunction

endpackage

// File: rtl/fp16_max2.sv
// Two-input FP16 max with index pass-through. Input a is always the lower index,
// so b only wins when it is valid and strictly greater (or a is masked out).
module fp16_max2
    import fp16_pkg::*;
#(
    parameter int IW = 4
) (
    input  fp16_t         a_val,
    input  logic [IW-1:0] a_idx,
    input  logic          a_ok,
    input  fp16_t         b_val,
    input  logic [IW-1:0] b_idx,
    input  logic          b_ok,
    output fp16_t         y_val,
    output logic [IW-1:0] y_idx,
    output logic          y_ok
);

    logic pick_b;

    assign pick_b = b_ok && (!a_ok || fp16_gt(b_val, a_val));
    assign y_val  = pick_b ? b_val : a_val;
    assign y_idx  = pick_b ? b_idx : a_idx;
    assign y_ok   = a_ok | b_ok;

endmodule

// File: rtl/fp16_argmax_stream.sv
// Streaming FP16 argmax: reduces LANES logits per beat into a running max and presents
// the one-hot/binary index and winning value once the last beat of a vector arrives.
//
// state    | meaning
// ST_ACCUM | accepting beats (reset state with cnt=0 is the idle condition)
// ST_HOLD  | result presented, waiting for out_ready
module fp16_argmax_stream
    import fp16_pkg::*;
#(
    parameter  int N     = 10,
    parameter  int LANES = 1,
    localparam int IDX_W = $clog2(N),
    localparam int BEATS = (N + LANES - 1) / LANES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*16-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N-1:0]          out_onehot,
    output logic [IDX_W-1:0]      out_idx,
    output logic [15:0]           out_max,
    output logic                  out_all_nan
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int EW    = $clog2(BEATS * LANES) + 1;

    argmax_state_t      state, state_nx;
    logic [CNT_W-1:0]   cnt;
    fp16_t              run_val;
    logic [IDX_W-1:0]   run_idx;
    logic               xfer, last;
    logic [EW-1:0]      base;

    fp16_t              lane_val [LANES];
    logic [IDX_W-1:0]   lane_idx [LANES];
    logic               lane_ok  [LANES];
    fp16_t              st_val   [LANES];
    logic [IDX_W-1:0]   st_idx   [LANES];
    logic               st_ok    [LANES];

    fp16_t              res_val;
    logic [IDX_W-1:0]   res_idx;
    logic               res_ok;

    assign base = EW'(cnt) * EW'(LANES);

    // Lanes past element N-1 only occur in the final beat; masking keeps them from winning.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [EW-1:0] elem;
        assign elem        = base + EW'(k);
        assign lane_val[k] = in_data[16*k +: 16];
        assign lane_idx[k] = elem[IDX_W-1:0];
        assign lane_ok[k]  = elem < EW'(N);
    end

    assign st_val[0] = lane_val[0];
    assign st_idx[0] = lane_idx[0];
    assign st_ok[0]  = lane_ok[0];

    for (genvar k = 1; k < LANES; k++) begin : g_tree
        fp16_max2 #(.IW(IDX_W)) u_max (
            .a_val (st_val[k-1]),
            .a_idx (st_idx[k-1]),
            .a_ok  (st_ok[k-1]),
            .b_val (lane_val[k]),
            .b_idx (lane_idx[k]),
            .b_ok  (lane_ok[k]),
            .y_val (st_val[k]),
            .y_idx (st_idx[k]),
            .y_ok  (st_ok[k])
        );
    end

    // With a masked running side on beat 0, the beat winner simply loads.
    fp16_max2 #(.IW(IDX_W)) u_run (
        .a_val (run_val),
        .a_idx (run_idx),
        .a_ok  (cnt != '0),
        .b_val (st_val[LANES-1]),
        .b_idx (st_idx[LANES-1]),
        .b_ok  (st_ok[LANES-1]),
        .y_val (res_val),
        .y_idx (res_idx),
        .y_ok  (res_ok)
    );

    assign out_valid = (state == ST_HOLD);
    assign in_ready  = rst_n & ((state == ST_ACCUM) | out_ready);
    assign xfer      = in_valid & in_ready;
    assign last      = (cnt == CNT_W'(BEATS - 1));

    always_comb begin
        state_nx = state;
        if (xfer && last)
            state_nx = ST_HOLD;
        else if ((state == ST_HOLD) && out_ready)
            state_nx = ST_ACCUM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_ACCUM;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            run_val     <= '0;
            run_idx     <= '0;
            out_onehot  <= '0;
            out_idx     <= '0;
            out_max     <= '0;
            out_all_nan <= 1'b0;
        end else if (xfer && res_ok) begin
            if (last) begin
                cnt         <= '0;
                out_idx     <= res_idx;
                out_onehot  <= N'(1) << res_idx;
                out_max     <= res_val;
                // NaN ranks lowest, so a NaN winner means the whole vector was NaN.
                out_all_nan <= fp16_is_nan(res_val);
            end else begin
                cnt     <= cnt + 1'b1;
                run_val <= res_val;
                run_idx <= res_idx;
            end
        end
    end

endmodule
